// File: rtl/div8.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, 8 RUN cycles per operation.
// A zero divisor skips RUN and reports quotient 8'hFF, remainder = dividend, div_by_zero = 1.
module div8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] work_q, work_d;   // dividend bits shift out MSB-first, quotient bits shift in
    logic [7:0] dvs_q, dvs_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rmd_q, rmd_d;
    logic       dbz_q, dbz_d;
    logic       zpend_q, zpend_d; // zero-divisor start accepted, DONE entered on the next edge

    logic [8:0] shifted;
    logic [8:0] diff;
    logic       borrow;
    logic       qbit;
    logic [7:0] next_rem;
    logic       accept;
    logic       unused_diff_msb;

    always_comb begin
        shifted  = {rem_q, work_q[7]};
        {borrow, diff} = {1'b0, shifted} - {2'b00, dvs_q};
        qbit     = ~borrow;
        next_rem = borrow ? shifted[7:0] : diff[7:0];
    end

    // Without a borrow the difference is below the divisor, so bit 8 is always zero.
    assign unused_diff_msb = diff[8];

    assign accept = start && !zpend_q && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        zpend_d = zpend_q;

        unique case (state_q)
            StIdle: begin
                if (zpend_q) begin
                    zpend_d = 1'b0;
                    quo_d   = 8'hFF;
                    rmd_d   = work_q;
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StRun: begin
                rem_d  = next_rem;
                work_d = {work_q[6:0], qbit};
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    quo_d   = {work_q[6:0], qbit};
                    rmd_d   = next_rem;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            work_d = dividend;
            dvs_d  = divisor;
            if (divisor != 8'd0) begin
                rem_d   = 8'd0;
                cnt_d   = 4'd8;
                dbz_d   = 1'b0;
                state_d = StRun;
            end else begin
                zpend_d = 1'b1;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= 8'd0;
            dvs_q   <= 8'd0;
            rem_q   <= 8'd0;
            cnt_q   <= 4'd0;
            quo_q   <= 8'd0;
            rmd_q   <= 8'd0;
            dbz_q   <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            zpend_q <= zpend_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_div8.sv
// Self-checking bench for div8: directed cases plus a random operand sweep against
// an arithmetic reference (a / b, a % b) with cycle-exact latency checks.
module tb_div8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] prev_q   = 8'd0;
    logic [7:0] prev_r   = 8'd0;
    logic       prev_dbz = 1'b0;

    div8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE or DONE; returns at posedge+1 of the done cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
        logic [7:0] eq, er;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        if (b != 8'd0) begin
            eq = a / b;
            er = a % b;
            for (int i = 0; i <= 8; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                check("busy", {31'd0, busy}, {31'd0, i < 8});
                check("done", {31'd0, done}, {31'd0, i == 8});
                check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
                if (i < 8) begin
                    check("hold_q", {24'd0, quotient}, {24'd0, prev_q});
                    check("hold_r", {24'd0, remainder}, {24'd0, prev_r});
                end
                if (poke && i == 2) begin
                    start    = 1'b1;
                    dividend = 8'd50;
                    divisor  = 8'd5;
                end else begin
                    start = 1'b0;
                end
            end
            check("quotient", {24'd0, quotient}, {24'd0, eq});
            check("remainder", {24'd0, remainder}, {24'd0, er});
            prev_q   = eq;
            prev_r   = er;
            prev_dbz = 1'b0;
        end else begin
            check("z_busy0", {31'd0, busy}, 32'd0);
            check("z_done0", {31'd0, done}, 32'd0);
            check("z_hold_q", {24'd0, quotient}, {24'd0, prev_q});
            check("z_hold_dbz", {31'd0, div_by_zero}, {31'd0, prev_dbz});
            @(posedge clk);
            #1;
            check("z_busy1", {31'd0, busy}, 32'd0);
            check("z_done1", {31'd0, done}, 32'd1);
            check("z_quotient", {24'd0, quotient}, 32'hFF);
            check("z_remainder", {24'd0, remainder}, {24'd0, a});
            check("z_dbz", {31'd0, div_by_zero}, 32'd1);
            prev_q   = 8'hFF;
            prev_r   = a;
            prev_dbz = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_q", {24'd0, quotient}, {24'd0, prev_q});
        check("idle_dbz", {31'd0, div_by_zero}, {31'd0, prev_dbz});
    endtask

    function automatic logic [7:0] pick(input bit allow_zero);
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0 && allow_zero) return 8'd0;
        if (sel == 1) return 8'd255;
        if (sel == 2) return 8'($urandom_range(1, 4));
        return 8'($urandom);
    endfunction

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #3;
        check("rst_q", {24'd0, quotient}, 32'd0);
        check("rst_r", {24'd0, remainder}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 100/7 with an ignored 50/5 start mid-run
        do_op(8'd100, 8'd7, 1'b1);
        idle_cycle();
        do_op(8'd255, 8'd1, 1'b0);
        idle_cycle();
        do_op(8'd5, 8'd65, 1'b0);
        idle_cycle();
        do_op(8'd255, 8'd255, 1'b0);
        idle_cycle();
        do_op(8'd200, 8'd0, 1'b0);
        do_op(8'd9, 8'd3, 1'b0);
        idle_cycle();
        do_op(8'd100, 8'd7, 1'b0);
        do_op(8'd50, 8'd5, 1'b0);
        idle_cycle();

        // Asynchronous reset in the middle of RUN
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_q", {24'd0, quotient}, 32'd0);
        check("arst_r", {24'd0, remainder}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
        prev_q   = 8'd0;
        prev_r   = 8'd0;
        prev_dbz = 1'b0;
        @(posedge clk);
        #1;
        check("arst_hold_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        idle_cycle();
        do_op(8'd9, 8'd4, 1'b0);
        idle_cycle();

        for (int n = 0; n < 1000; n++) begin
            do_op(pick(1'b0), pick(1'b1), 1'b0);
            if ($urandom_range(0, 3) != 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
